delay_alloc_ctrl: RTL
=====================

// Module: delay_alloc_ctrl
// PURPOSE
//  Services alloc_delay pulses from the control unit: carves delay-line regions out of the shared delay RAM,
//  one bump allocator per pipeline (pipeline p owns RAM half p), zero-fills each new region, then publishes
//  a descriptor {base, size, initial read pointer} to that pipeline's delay table. pipeline_full_reset frees
//  all of a pipeline's regions. Sits between control_unit and the delay RAM / per-pipeline delay tables.
// PARAMETERS
//  ADDR_WIDTH   16  delay RAM word address width; each pipeline half spans 2^(ADDR_WIDTH-1) words
//  MAX_DELAYS   16  descriptor slots per pipeline
//  DATA_WIDTH   16  delay RAM word width (clear data)
// PORTS
//  clk              in   1              system clock
//  reset            in   1              synchronous, active-high
//  alloc_req        in   2              one-cycle request pulse per pipeline (control_unit alloc_delay)
//  alloc_size       in   32             requested length in words, valid with alloc_req
//  alloc_init_delay in   32             initial read-behind-write distance in words, valid with alloc_req
//  free_pipeline    in   2              one-cycle pulse: release all regions of pipeline p (full reset)
//  busy             out  1              allocator not IDLE or a request pending
//  alloc_done       out  1              pulse: descriptor written, region cleared
//  alloc_fail       out  1              pulse: request rejected (no descriptor, no RAM writes)
//  desc_we          out  2              pulse: write descriptor into pipeline p table
//  desc_index       out  clog2(MAX_DELAYS) slot index
//  desc_base        out  ADDR_WIDTH     region base address
//  desc_size        out  ADDR_WIDTH     region length (words)
//  desc_rd_ptr      out  ADDR_WIDTH     base + init_delay
//  mem_we           out  1              delay RAM write strobe (clear)
//  mem_addr         out  ADDR_WIDTH     delay RAM address
//  mem_wdata        out  DATA_WIDTH     always 0
// BEHAVIOUR
//  Reset: all pulses/strobes 0, busy 0, bump_ptr[p]=0, slot_cnt[p]=0, pending cleared, state IDLE.
//  Pending: alloc_req[p] latches {size,init} into pend[p]; second req for same p while pending overwrites it.
//  Arbitration in IDLE: pend[0] before pend[1]; accept takes 1 cycle IDLE->CHECK.
//  CHECK (1 cycle) fails if: size==0; size > 2^(ADDR_WIDTH-1) - bump_ptr[p]; init_delay >= size;
//   slot_cnt[p]==MAX_DELAYS. Compare at 33 bits, no truncation. Fail -> alloc_fail pulse, IDLE.
//  Pass -> CLEAR: base = {p, bump_ptr[p]}; mem_we=1 one word/cycle, mem_addr base..base+size-1.
//  After last clear word -> PUBLISH (1 cycle): desc_we[p]=1, desc_index=slot_cnt[p], bump_ptr[p]+=size,
//   slot_cnt[p]+=1, alloc_done=1; next cycle IDLE. Latency for size N: N+3 cycles accept-to-done.
//  free_pipeline[p]: bump_ptr[p]=0, slot_cnt[p]=0, pend[p] dropped. If FSM is CHECK/CLEAR/PUBLISH for p:
//   abort to IDLE same cycle, no desc_we, no alloc_done/fail. Other pipeline's job unaffected.
//  Simultaneous free_pipeline[p] and alloc_req[p]: free applies first, new request is latched.
//  Exact fill (bump_ptr reaches 2^(ADDR_WIDTH-1)) is legal; next nonzero request fails.
//  Reset mid-CLEAR: immediate IDLE, mem_we deasserts same edge; RAM contents undefined.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, CHECK, CLEAR, PUBLISH), descriptor field widths.
//  Sub-module: delay_clear_seq (base,len,start,abort -> mem_we/mem_addr, last) for the CLEAR walk.
// TESTING
//  alloc_req=01, size 4, init 2 -> mem_we addr 0..3, desc_we=01 idx0 base0 size4 rd_ptr2, done at cycle 7.
//  alloc_req=11 same cycle, size 2 each -> p0 served first (base 0), then p1 base 0x8000, both done.
//  size 5 init 5 -> alloc_fail, no mem_we, no desc_we; size 0 -> alloc_fail.
//  Fill p0 to 0x8000 exactly, then size 1 -> alloc_fail; MAX_DELAYS+1 small allocs -> last fails.
//  free_pipeline=01 during p0 CLEAR of size 100 -> mem_we drops, no done; next p0 alloc gets base 0, idx0.
//  reset asserted mid-CLEAR -> all outputs 0 next cycle, pending lost, bump pointers 0.

Source files
------------

// File: rtl/delay_alloc_ctrl_pkg.sv
// Shared definitions for the delay-line allocator: FSM encoding, descriptor widths, pending-request record.
package delay_alloc_ctrl_pkg;

  localparam int DAC_ADDR_WIDTH = 16;
  localparam int DAC_MAX_DELAYS = 16;
  localparam int DAC_DATA_WIDTH = 16;
  localparam int DAC_REQ_WIDTH  = 32;
  localparam int DAC_IDX_WIDTH  = $clog2(DAC_MAX_DELAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CLEAR,
    S_PUBLISH
  } alloc_state_e;

  typedef struct packed {
    logic [DAC_REQ_WIDTH-1:0] size;
    logic [DAC_REQ_WIDTH-1:0] init_delay;
  } alloc_req_t;

endpackage

// File: rtl/delay_alloc_ctrl_if.sv
// Bundle between control unit, delay RAM and per-pipeline delay tables; slave side is the allocator.
interface delay_alloc_ctrl_if
  import delay_alloc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DAC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int IDX_WIDTH  = DAC_IDX_WIDTH,
  parameter int REQ_WIDTH  = DAC_REQ_WIDTH
);

  logic [1:0]            alloc_req;
  logic [REQ_WIDTH-1:0]  alloc_size;
  logic [REQ_WIDTH-1:0]  alloc_init_delay;
  logic [1:0]            free_pipeline;
  logic                  busy;
  logic                  alloc_done;
  logic                  alloc_fail;
  logic [1:0]            desc_we;
  logic [IDX_WIDTH-1:0]  desc_index;
  logic [ADDR_WIDTH-1:0] desc_base;
  logic [ADDR_WIDTH-1:0] desc_size;
  logic [ADDR_WIDTH-1:0] desc_rd_ptr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output alloc_req, alloc_size, alloc_init_delay, free_pipeline,
    input  busy, alloc_done, alloc_fail, desc_we, desc_index, desc_base,
           desc_size, desc_rd_ptr, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  alloc_req, alloc_size, alloc_init_delay, free_pipeline,
    output busy, alloc_done, alloc_fail, desc_we, desc_index, desc_base,
           desc_size, desc_rd_ptr, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/delay_alloc_ctrl_clear_seq.sv
// Zero-fill walker: one RAM write per cycle from base to base+len-1; last flags the final word.
module delay_clear_seq
  import delay_alloc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DAC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_len,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_last
);

  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remain;

  // Abort wins over start so a freed pipeline never begins a new walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_addr   <= i_base;
      r_remain <= i_len;
    end else if (r_active) begin
      r_addr   <= r_addr + ADDR_WIDTH'(1);
      r_remain <= r_remain - ADDR_WIDTH'(1);
      if (r_remain == ADDR_WIDTH'(1)) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_mem_we   = r_active;
  assign o_mem_addr = r_addr;
  assign o_last     = r_active && (r_remain == ADDR_WIDTH'(1));

endmodule

// File: rtl/delay_alloc_ctrl.sv
// Per-pipeline bump allocator over the shared delay RAM: checks, zero-fills and publishes delay regions.
module delay_alloc_ctrl
  import delay_alloc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DAC_ADDR_WIDTH,
  parameter int MAX_DELAYS = DAC_MAX_DELAYS,
  parameter int DATA_WIDTH = DAC_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  delay_alloc_ctrl_if.slave bus
);

  localparam int IDX_W  = $clog2(MAX_DELAYS);
  localparam int SLOT_W = $clog2(MAX_DELAYS + 1);
  localparam int CMP_W  = DAC_REQ_WIDTH + 1;
  localparam logic [CMP_W-1:0] HALF_WORDS = {{(CMP_W-1){1'b0}}, 1'b1} << (ADDR_WIDTH - 1);

  alloc_state_e          r_state;
  logic                  r_cur_p;
  alloc_req_t            r_cur;
  alloc_req_t            r_pend [2];
  logic [1:0]            r_pend_v;
  logic [ADDR_WIDTH-1:0] r_bump [2];
  logic [SLOT_W-1:0]     r_slot [2];
  logic                  r_fail;
  logic [IDX_W-1:0]      r_desc_index;
  logic [ADDR_WIDTH-1:0] r_desc_base;
  logic [ADDR_WIDTH-1:0] r_desc_size;
  logic [ADDR_WIDTH-1:0] r_desc_rd_ptr;

  logic                  w_free_cur;
  logic [1:0]            w_pend_eff;
  logic                  w_pick;
  logic [ADDR_WIDTH-1:0] w_bump_cur;
  logic [SLOT_W-1:0]     w_slot_cur;
  logic [CMP_W-1:0]      w_room;
  logic                  w_fail;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_last;
  logic                  w_publish;

  // A pending request for a pipeline being freed this cycle is not eligible.
  assign w_free_cur = bus.free_pipeline[r_cur_p];
  assign w_pend_eff = r_pend_v & ~bus.free_pipeline;
  assign w_pick     = ~w_pend_eff[0];
  assign w_bump_cur = r_bump[r_cur_p];
  assign w_slot_cur = r_slot[r_cur_p];
  assign w_room     = HALF_WORDS - {{(CMP_W-ADDR_WIDTH){1'b0}}, w_bump_cur};

  // Size is compared one bit wider than the request so huge sizes cannot wrap into range.
  assign w_fail = (r_cur.size == '0)
               || ({1'b0, r_cur.size} > w_room)
               || (r_cur.init_delay >= r_cur.size)
               || (w_slot_cur == SLOT_W'(MAX_DELAYS));

  assign w_base    = {r_cur_p, w_bump_cur[ADDR_WIDTH-2:0]};
  assign w_start   = (r_state == S_CHECK) && !w_free_cur && !w_fail;
  assign w_abort   = (r_state == S_CLEAR) && w_free_cur;
  assign w_publish = (r_state == S_PUBLISH) && !w_free_cur;

  delay_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .i_base     (w_base),
    .i_len      (r_cur.size[ADDR_WIDTH-1:0]),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .o_mem_we   (bus.mem_we),
    .o_mem_addr (bus.mem_addr),
    .o_last     (w_last)
  );

  // Free is applied before a same-cycle request so the new request survives the release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_p       <= 1'b0;
      r_cur         <= '0;
      r_pend_v      <= '0;
      r_fail        <= 1'b0;
      r_desc_index  <= '0;
      r_desc_base   <= '0;
      r_desc_size   <= '0;
      r_desc_rd_ptr <= '0;
      for (int p = 0; p < 2; p++) begin
        r_pend[p] <= '0;
        r_bump[p] <= '0;
        r_slot[p] <= '0;
      end
    end else begin
      r_fail <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (bus.free_pipeline[p]) begin
          r_bump[p]   <= '0;
          r_slot[p]   <= '0;
          r_pend_v[p] <= 1'b0;
        end
        if (bus.alloc_req[p]) begin
          r_pend_v[p] <= 1'b1;
          r_pend[p]   <= {bus.alloc_size, bus.alloc_init_delay};
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (|w_pend_eff) begin
            r_cur_p <= w_pick;
            r_cur   <= r_pend[w_pick];
            r_state <= S_CHECK;
            if (!bus.alloc_req[w_pick]) begin
              r_pend_v[w_pick] <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          if (w_free_cur) begin
            r_state <= S_IDLE;
          end else if (w_fail) begin
            r_fail  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (w_free_cur) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_state       <= S_PUBLISH;
            r_desc_index  <= w_slot_cur[IDX_W-1:0];
            r_desc_base   <= w_base;
            r_desc_size   <= r_cur.size[ADDR_WIDTH-1:0];
            r_desc_rd_ptr <= w_base + r_cur.init_delay[ADDR_WIDTH-1:0];
          end
        end
        S_PUBLISH: begin
          r_state <= S_IDLE;
          if (!w_free_cur) begin
            r_bump[r_cur_p] <= w_bump_cur + r_cur.size[ADDR_WIDTH-1:0];
            r_slot[r_cur_p] <= w_slot_cur + SLOT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE) || (|r_pend_v);
  assign bus.alloc_done  = w_publish;
  assign bus.alloc_fail  = r_fail;
  assign bus.desc_we     = {w_publish & r_cur_p, w_publish & ~r_cur_p};
  assign bus.desc_index  = r_desc_index;
  assign bus.desc_base   = r_desc_base;
  assign bus.desc_size   = r_desc_size;
  assign bus.desc_rd_ptr = r_desc_rd_ptr;
  assign bus.mem_wdata   = '0;

endmodule
